// File: rtl/sonar_pkg.sv
// -----------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the sonar measurement scheduler.
//   sched_state_t  : scheduler FSM states
//   SENSOR_FRONT/BACK : encoding of the sensor select (sel) signal
//   DIST_W / DIST_NONE : distance width and "no obstacle" value
//   slot_sensor()  : maps a slot index onto the sensor that owns it
// -----------------------------------------------------------------------------
package sonar_pkg;

    localparam int DIST_W = 12;
    localparam logic [DIST_W-1:0] DIST_NONE = 12'hFFF;

    localparam logic SENSOR_FRONT = 1'b0;
    localparam logic SENSOR_BACK  = 1'b1;

    localparam int SLOT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_ARM,
        ST_WAIT,
        ST_DONE
    } sched_state_t;

    // Slot indices below the ratio belong to the primary sensor; the slot
    // equal to the ratio is the single slot handed to the secondary sensor.
    function automatic logic slot_sensor(input logic [SLOT_W-1:0] slot,
                                         input logic [SLOT_W-1:0] ratio,
                                         input logic              primary);
        return (slot == ratio) ? ~primary : primary;
    endfunction

endpackage

// File: rtl/sonar_slot_sel.sv
// -----------------------------------------------------------------------------
// sonar_slot_sel
// Slot counter and sensor selection for the sonar scheduler.
//   CLOCK_50   in  : system clock
//   reset      in  : asynchronous, active-low reset
//   direction  in  : 0 = forward (front is primary), 1 = reverse (back primary)
//   i_select   in  : pick a sensor when leaving IDLE (counter not advanced)
//   i_advance  in  : end of a measurement; advance the slot and re-pick
//   o_sel      out : sensor owning the current slot (0 = front, 1 = back)
// A direction change is only noticed at a selection point, so a measurement
// already in flight keeps its sensor; the new direction starts at slot 0.
// -----------------------------------------------------------------------------
module sonar_slot_sel
    import sonar_pkg::*;
#(
    parameter int PRIO_RATIO = 3
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic direction,
    input  logic i_select,
    input  logic i_advance,
    output logic o_sel
);

    localparam logic [SLOT_W-1:0] RATIO    = SLOT_W'(PRIO_RATIO);
    localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);

    logic [SLOT_W-1:0] r_slot;
    logic              r_dir_ref;   // direction the current slot counting refers to
    logic              r_sel;

    logic              w_changed;
    logic              w_update;
    logic [SLOT_W-1:0] w_slot_inc;
    logic [SLOT_W-1:0] w_slot_next;

    always_comb begin
        w_changed   = (direction != r_dir_ref);
        w_update    = i_select | i_advance;
        w_slot_inc  = (r_slot >= RATIO) ? '0 : r_slot + SLOT_ONE;
        w_slot_next = r_slot;
        if (w_changed) begin
            w_slot_next = '0;
        end else if (i_advance) begin
            w_slot_next = w_slot_inc;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_slot    <= '0;
            r_dir_ref <= 1'b0;
            r_sel     <= SENSOR_FRONT;
        end else if (w_update) begin
            r_slot    <= w_slot_next;
            r_dir_ref <= direction;
            r_sel     <= slot_sensor(w_slot_next, RATIO, direction);
        end
    end

    assign o_sel = r_sel;

endmodule

// File: rtl/sonar_scheduler.sv
// -----------------------------------------------------------------------------
// sonar_scheduler
// Time-multiplexes measurement requests to the front and back ranging engines
// so that only one transducer fires at a time, weighting slots toward the
// sensor facing the direction of travel.
//
// Parameters: GAP_CYCLES (idle gap), TIMEOUT_CYCLES (max wait for valid),
//             PRIO_RATIO (primary slots per secondary slot, 1..15)
// Ports:
//   CLOCK_50, reset (async, active-low)
//   enable, direction                      : control from motion logic
//   ready_*/valid_*/distance_*             : engine handshake and result
//   start_*                                : one-cycle registered start request
//   dist_*, new_*, timeout_*               : latched result, update pulse,
//                                            sticky timeout flag
//   sel, busy                              : current slot owner, FSM not idle
// Optional build macro SONAR_SCHED_STATS_EN adds the 16-bit saturating
// counters meas_cnt_front/back and to_cnt_front/back.
// -----------------------------------------------------------------------------
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int GAP_CYCLES     = 3_000_000,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int PRIO_RATIO     = 3
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              enable,
    input  logic              direction,
    input  logic              ready_front,
    input  logic              ready_back,
    input  logic              valid_front,
    input  logic              valid_back,
    input  logic [DIST_W-1:0] distance_front,
    input  logic [DIST_W-1:0] distance_back,
    output logic              start_front,
    output logic              start_back,
    output logic [DIST_W-1:0] dist_front,
    output logic [DIST_W-1:0] dist_back,
    output logic              new_front,
    output logic              new_back,
    output logic              timeout_front,
    output logic              timeout_back,
    output logic              sel,
    output logic              busy
`ifdef SONAR_SCHED_STATS_EN
    ,
    output logic [15:0]       meas_cnt_front,
    output logic [15:0]       meas_cnt_back,
    output logic [15:0]       to_cnt_front,
    output logic [15:0]       to_cnt_back
`endif
);

    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    // The DONE cycle already counts as the first gap cycle, so GAP dwells
    // GAP_CYCLES-1 cycles and consecutive starts are GAP_CYCLES+2 apart at best.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    // Loaded when start is issued; valid is accepted while the counter runs
    // from TIMEOUT_CYCLES-1 down to 0 inclusive.
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

    sched_state_t      r_state, w_state_next;
    logic [GAP_W-1:0]  r_gap_cnt, w_gap_next;
    logic [TO_W-1:0]   r_to_cnt, w_to_next;
    logic              r_start_front, w_start_front_next;
    logic              r_start_back, w_start_back_next;
    logic              r_new_front, w_new_front_next;
    logic              r_new_back, w_new_back_next;
    logic              r_timeout_front, w_timeout_front_next;
    logic              r_timeout_back, w_timeout_back_next;
    logic [DIST_W-1:0] r_dist_front, w_dist_front_next;
    logic [DIST_W-1:0] r_dist_back, w_dist_back_next;

    logic w_sel;
    logic w_select;
    logic w_advance;
    logic w_ready_sel;
    logic w_valid_sel;

    sonar_slot_sel #(
        .PRIO_RATIO (PRIO_RATIO)
    ) u_slot_sel (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .direction (direction),
        .i_select  (w_select),
        .i_advance (w_advance),
        .o_sel     (w_sel)
    );

    // Only the selected engine is ever looked at; the other one's handshake
    // is ignored entirely.
    assign w_ready_sel = (w_sel == SENSOR_BACK) ? ready_back : ready_front;
    assign w_valid_sel = (w_sel == SENSOR_BACK) ? valid_back : valid_front;

    always_comb begin
        w_state_next         = r_state;
        w_gap_next           = r_gap_cnt;
        w_to_next            = r_to_cnt;
        w_start_front_next   = 1'b0;
        w_start_back_next    = 1'b0;
        w_new_front_next     = 1'b0;
        w_new_back_next      = 1'b0;
        w_timeout_front_next = r_timeout_front;
        w_timeout_back_next  = r_timeout_back;
        w_dist_front_next    = r_dist_front;
        w_dist_back_next     = r_dist_back;
        w_select             = 1'b0;
        w_advance            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_select     = 1'b1;
                    w_gap_next   = GAP_LOAD;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (r_gap_cnt <= GAP_ONE) begin
                    w_state_next = ST_ARM;
                end else begin
                    w_gap_next = r_gap_cnt - GAP_ONE;
                end
            end
            ST_ARM: begin
                if (w_ready_sel) begin
                    if (w_sel == SENSOR_BACK) begin
                        w_start_back_next = 1'b1;
                    end else begin
                        w_start_front_next = 1'b1;
                    end
                    w_to_next    = TO_LOAD;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // valid is tested first so it wins over a same-cycle expiry
                if (w_valid_sel) begin
                    if (w_sel == SENSOR_BACK) begin
                        w_dist_back_next    = distance_back;
                        w_new_back_next     = 1'b1;
                        w_timeout_back_next = 1'b0;
                    end else begin
                        w_dist_front_next    = distance_front;
                        w_new_front_next     = 1'b1;
                        w_timeout_front_next = 1'b0;
                    end
                    w_state_next = ST_DONE;
                end else if (r_to_cnt == '0) begin
                    if (w_sel == SENSOR_BACK) begin
                        w_timeout_back_next = 1'b1;
                    end else begin
                        w_timeout_front_next = 1'b1;
                    end
                    w_state_next = ST_DONE;
                end else begin
                    w_to_next = r_to_cnt - TO_ONE;
                end
            end
            ST_DONE: begin
                w_advance = 1'b1;
                if (enable) begin
                    w_gap_next   = GAP_LOAD;
                    w_state_next = ST_GAP;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_gap_cnt       <= '0;
            r_to_cnt        <= '0;
            r_start_front   <= 1'b0;
            r_start_back    <= 1'b0;
            r_new_front     <= 1'b0;
            r_new_back      <= 1'b0;
            r_timeout_front <= 1'b0;
            r_timeout_back  <= 1'b0;
            r_dist_front    <= DIST_NONE;
            r_dist_back     <= DIST_NONE;
        end else begin
            r_state         <= w_state_next;
            r_gap_cnt       <= w_gap_next;
            r_to_cnt        <= w_to_next;
            r_start_front   <= w_start_front_next;
            r_start_back    <= w_start_back_next;
            r_new_front     <= w_new_front_next;
            r_new_back      <= w_new_back_next;
            r_timeout_front <= w_timeout_front_next;
            r_timeout_back  <= w_timeout_back_next;
            r_dist_front    <= w_dist_front_next;
            r_dist_back     <= w_dist_back_next;
        end
    end

    assign start_front   = r_start_front;
    assign start_back    = r_start_back;
    assign new_front     = r_new_front;
    assign new_back      = r_new_back;
    assign timeout_front = r_timeout_front;
    assign timeout_back  = r_timeout_back;
    assign dist_front    = r_dist_front;
    assign dist_back     = r_dist_back;
    assign sel           = w_sel;
    assign busy          = (r_state != ST_IDLE);

`ifdef SONAR_SCHED_STATS_EN
    // Index: 0 meas front, 1 meas back, 2 timeout front, 3 timeout back
    logic [15:0] r_stat [4];
    logic [3:0]  w_stat_inc;
    logic        w_wait_valid;
    logic        w_wait_expire;

    always_comb begin
        w_wait_valid  = (r_state == ST_WAIT) && w_valid_sel;
        w_wait_expire = (r_state == ST_WAIT) && !w_valid_sel && (r_to_cnt == '0);
        w_stat_inc[0] = w_wait_valid  && (w_sel == SENSOR_FRONT);
        w_stat_inc[1] = w_wait_valid  && (w_sel == SENSOR_BACK);
        w_stat_inc[2] = w_wait_expire && (w_sel == SENSOR_FRONT);
        w_stat_inc[3] = w_wait_expire && (w_sel == SENSOR_BACK);
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stat
            always_ff @(posedge CLOCK_50 or negedge reset) begin
                if (!reset) begin
                    r_stat[gi] <= '0;
                end else if (w_stat_inc[gi] && (r_stat[gi] != 16'hFFFF)) begin
                    r_stat[gi] <= r_stat[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign meas_cnt_front = r_stat[0];
    assign meas_cnt_back  = r_stat[1];
    assign to_cnt_front   = r_stat[2];
    assign to_cnt_back    = r_stat[3];
`endif

endmodule

// File: tb/tb_sonar_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sonar_scheduler
// Drives the scheduler through directed phases with randomized engine
// latencies, distances, foreign valids and ready holds. Expected values come
// from a measurement-level model: slot ownership from the weighting rule,
// start times from "previous measurement end + gap", and per-sensor result
// registers updated on valid / timeout.
// -----------------------------------------------------------------------------
module tb_sonar_scheduler;

    localparam int GAP  = 10;
    localparam int TMO  = 50;
    localparam int PRIO = 3;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        direction = 1'b0;
    logic        ready_front = 1'b1;
    logic        ready_back = 1'b1;
    logic        valid_front = 1'b0;
    logic        valid_back = 1'b0;
    logic [11:0] distance_front = '0;
    logic [11:0] distance_back = '0;
    logic        start_front, start_back;
    logic [11:0] dist_front, dist_back;
    logic        new_front, new_back;
    logic        timeout_front, timeout_back;
    logic        sel, busy;

    sonar_scheduler #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .PRIO_RATIO     (PRIO)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .enable         (enable),
        .direction      (direction),
        .ready_front    (ready_front),
        .ready_back     (ready_back),
        .valid_front    (valid_front),
        .valid_back     (valid_back),
        .distance_front (distance_front),
        .distance_back  (distance_back),
        .start_front    (start_front),
        .start_back     (start_back),
        .dist_front     (dist_front),
        .dist_back      (dist_back),
        .new_front      (new_front),
        .new_back       (new_back),
        .timeout_front  (timeout_front),
        .timeout_back   (timeout_back),
        .sel            (sel),
        .busy           (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_rel = 0;
    int last_end = 0;
    int en_cycle = 0;
    int meas_no = 0;
    bit after_idle = 1'b1;

    // reference model state
    int          mdl_slot = 0;
    bit          mdl_dir = 1'b0;
    logic [11:0] exp_dist [2];
    bit          exp_to [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        cyc++;
        ready_front = (cyc >= ready_rel);
        ready_back  = (cyc >= ready_rel);
        chk("start_excl", {31'd0, start_front & start_back}, 32'd0);
    endtask

    function automatic logic [11:0] dist_of(input bit s);
        return s ? dist_back : dist_front;
    endfunction
    function automatic logic new_of(input bit s);
        return s ? new_back : new_front;
    endfunction
    function automatic logic timeout_of(input bit s);
        return s ? timeout_back : timeout_front;
    endfunction

    task automatic set_valid(input bit s, input logic v, input logic [11:0] d);
        if (s) begin
            valid_back = v;
            distance_back = d;
        end else begin
            valid_front = v;
            distance_front = d;
        end
    endtask

    // Every (PRIO+1)-th slot of a cycle belongs to the secondary sensor.
    function automatic bit mdl_sensor();
        return (mdl_slot == PRIO) ? !mdl_dir : mdl_dir;
    endfunction
    function automatic void mdl_idle_exit();
        if (direction != mdl_dir) begin
            mdl_slot = 0;
            mdl_dir = direction;
        end
    endfunction
    function automatic void mdl_done();
        if (direction != mdl_dir) begin
            mdl_slot = 0;
            mdl_dir = direction;
        end else begin
            mdl_slot = (mdl_slot + 1) % (PRIO + 1);
        end
    endfunction
    function automatic void mdl_reset();
        mdl_slot = 0;
        mdl_dir = 1'b0;
        exp_dist[0] = 12'hFFF;
        exp_dist[1] = 12'hFFF;
        exp_to[0] = 1'b0;
        exp_to[1] = 1'b0;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_dist_front"}, {20'd0, dist_front}, 32'd4095);
        chk({tag, "_dist_back"}, {20'd0, dist_back}, 32'd4095);
        chk({tag, "_sel"}, {31'd0, sel}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_starts"}, {30'd0, start_front, start_back}, 32'd0);
        chk({tag, "_news"}, {30'd0, new_front, new_back}, 32'd0);
        chk({tag, "_timeouts"}, {30'd0, timeout_front, timeout_back}, 32'd0);
    endtask

    // One measurement slot. lat >= TMO means the engine never answers.
    // fa > 0: the unselected engine pulses valid fa cycles after the start.
    // hold: extra cycles the engines report not-ready past the natural ARM cycle.
    task automatic measure(input int lat, input logic [11:0] d, input int fa,
                           input int hold, input bit flip, input bit drop_en);
        int s, exp_s, target, n;
        bit es, fdrv;
        logic [11:0] fd;
        es = mdl_sensor();
        exp_s = after_idle ? en_cycle + GAP + 1 : last_end + GAP + 2;
        ready_rel = (hold > 0) ? exp_s - 1 + hold : 0;
        exp_s += hold;
        s = -1;
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (start_front || start_back) begin
                s = cyc;
                break;
            end
        end
        if (s < 0) begin
            chk("start_seen", 32'd0, 32'd1);
            return;
        end
        chk("start_cycle", s, exp_s);
        chk("sel", {31'd0, sel}, {31'd0, es});
        chk("start_front", {31'd0, start_front}, {31'd0, !es});
        chk("start_back", {31'd0, start_back}, {31'd0, es});
        chk("busy_meas", {31'd0, busy}, 32'd1);
        tick();
        chk("start_pulse", {31'd0, start_front | start_back}, 32'd0);
        if (flip) direction = !direction;
        if (drop_en) enable = 1'b0;
        target = (lat < TMO) ? s + lat : s + TMO - 1;
        fdrv = 1'b0;
        fd = '0;
        while (cyc < target) begin
            tick();
            if (fdrv) begin
                set_valid(!es, 1'b0, fd);
                fdrv = 1'b0;
                chk("foreign_dist", {20'd0, dist_of(!es)}, {20'd0, exp_dist[!es]});
                chk("foreign_new", {31'd0, new_of(!es)}, 32'd0);
            end
            if (fa > 0 && cyc == s + fa && cyc < target) begin
                fd = 12'($urandom);
                set_valid(!es, 1'b1, fd);
                fdrv = 1'b1;
            end
        end
        chk("to_before", {31'd0, timeout_of(es)}, {31'd0, exp_to[es]});
        if (lat < TMO) begin
            set_valid(es, 1'b1, d);
            tick();
            set_valid(es, 1'b0, d);
            exp_dist[es] = d;
            exp_to[es] = 1'b0;
            chk("dist_sel", {20'd0, dist_of(es)}, {20'd0, d});
            chk("new_sel", {31'd0, new_of(es)}, 32'd1);
            chk("to_cleared", {31'd0, timeout_of(es)}, 32'd0);
        end else begin
            tick();
            exp_to[es] = 1'b1;
            chk("to_set", {31'd0, timeout_of(es)}, 32'd1);
            chk("dist_held", {20'd0, dist_of(es)}, {20'd0, exp_dist[es]});
            chk("new_on_to", {31'd0, new_of(es)}, 32'd0);
        end
        chk("other_dist", {20'd0, dist_of(!es)}, {20'd0, exp_dist[!es]});
        chk("other_to", {31'd0, timeout_of(!es)}, {31'd0, exp_to[!es]});
        chk("other_new", {31'd0, new_of(!es)}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd1);
        last_end = target;
        after_idle = 1'b0;
        mdl_done();
        $display("meas %0d: sensor=%s start=%0d lat=%0d dist=%0d timeout=%0d foreign=%0d hold=%0d",
                 meas_no, es ? "back" : "front", s, lat, dist_of(es), timeout_of(es), fa, hold);
        meas_no++;
        tick();
        chk("new_pulse", {31'd0, new_of(es)}, 32'd0);
        if (drop_en) chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic rand_measure(input bit flip, input bit drop_en);
        int lat, lim, fa, hold;
        lat = ($urandom_range(0, 3) == 0) ? TMO : int'($urandom_range(2, TMO - 1));
        lim = (lat < TMO) ? lat : TMO - 1;
        fa = ($urandom_range(0, 1) == 1 && lim > 2) ? int'($urandom_range(2, lim - 1)) : 0;
        hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
        measure(lat, 12'($urandom_range(0, 4094)), fa, hold, flip, drop_en);
    endtask

    initial begin
        int n, seen;
        bit got;
        mdl_reset();

        // reset state
        repeat (3) tick();
        check_reset_values("rst");
        reset = 1'b1;
        tick();

        // forward sequencing, 20-cycle engine latency -> F,F,F,B at 32-cycle spacing
        direction = 1'b0;
        enable = 1'b1;
        en_cycle = cyc;
        after_idle = 1'b1;
        mdl_idle_exit();
        for (int i = 0; i < 8; i++) begin
            measure(20, (i == 2 || i == 3) ? 12'd850 : 12'($urandom_range(0, 4094)), 0, 0, 1'b0, 1'b0);
        end

        // back timeout, then a back result of 400 clears the flag
        while (mdl_sensor() != 1'b1) measure(12, 12'($urandom_range(0, 4094)), 5, 0, 1'b0, 1'b0);
        measure(TMO, 12'd0, 7, 0, 1'b0, 1'b0);
        while (mdl_sensor() != 1'b1) measure(9, 12'($urandom_range(0, 4094)), 0, 0, 1'b0, 1'b0);
        measure(30, 12'd400, 0, 0, 1'b0, 1'b0);

        // valid in the same cycle the timeout expires, with a foreign valid earlier
        measure(TMO - 1, 12'($urandom_range(0, 4094)), 4, 0, 1'b0, 1'b0);

        // randomized slots
        for (int i = 0; i < 16; i++) rand_measure(1'b0, 1'b0);

        // direction flip during WAIT
        measure(25, 12'($urandom_range(0, 4094)), 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) rand_measure(1'b0, 1'b0);

        // enable dropped during WAIT: result still latches, then no more starts
        measure(15, 12'($urandom_range(0, 4094)), 0, 0, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (start_front || start_back) seen++;
        end
        chk("no_start_idle", seen, 32'd0);
        chk("busy_stays_idle", {31'd0, busy}, 32'd0);

        // reset asserted in WAIT
        enable = 1'b1;
        en_cycle = cyc;
        after_idle = 1'b1;
        mdl_idle_exit();
        got = 1'b0;
        n = 0;
        while (n < 400 && !got) begin
            tick();
            n++;
            got = start_front | start_back;
        end
        chk("rst_start_seen", {31'd0, got}, 32'd1);
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        tick();
        enable = 1'b0;
        reset = 1'b1;
        mdl_reset();
        // stale results after reset release are ignored in IDLE
        set_valid(1'b0, 1'b1, 12'd123);
        set_valid(1'b1, 1'b1, 12'd321);
        tick();
        set_valid(1'b0, 1'b0, 12'd0);
        set_valid(1'b1, 1'b0, 12'd0);
        check_reset_values("stale");
        tick();
        check_reset_values("stale2");

        // restart after reset; direction is currently reverse
        enable = 1'b1;
        en_cycle = cyc;
        after_idle = 1'b1;
        mdl_idle_exit();
        for (int i = 0; i < 5; i++) rand_measure(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
